// File: rtl/axi_infer_pkg.sv
// Shared definitions for the accelerator inference AXI master: FSM states,
// fixed AXI field encodings and the prediction word layout.
package axi_infer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_GAP   = 3'd5,
    ST_FIN   = 3'd6
  } state_e;

  localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_CACHE_BM   = 4'b0011;

  localparam int PRED_VALID_BIT = 31;

endpackage

// File: rtl/axi_infer_master_chan.sv
// Registered single-beat AXI request holder: loads a payload, raises valid on
// the next cycle and keeps valid/payload frozen until the ready handshake.
module axi_single_beat_chan #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] payload_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] payload_o
);

  logic         valid_q;
  logic [W-1:0] payload_q;

  // Valid/payload register; a load is ignored while a beat is still pending.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      payload_q <= {W{1'b0}};
    end else if (valid_q) begin
      if (ready_i) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= 1'b1;
      end
    end else if (load_i) begin
      valid_q   <= 1'b1;
      payload_q <= payload_i;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/axi_infer_master.sv
// AXI4 master that writes one instruction word to the accelerator and then
// polls its prediction word until the valid bit is set, an error, or timeout.
module axi_infer_master
  import axi_infer_pkg::*;
#(
  parameter int                ID_W       = 12,
  parameter int                ADDR_W     = 64,
  parameter int                DATA_W     = 128,
  parameter logic [ID_W-1:0]   AXI_ID     = 12'h000,
  parameter logic [ADDR_W-1:0] INSTR_ADDR = 64'h0,
  parameter logic [ADDR_W-1:0] PRED_ADDR  = 64'h10,
  parameter int                POLL_MAX   = 1024,
  parameter int                POLL_GAP   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         instr,
  output logic                busy,
  output logic                done,
  output logic [31:0]         result,
  output logic                error,
  output logic                timeout,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache,
  output logic [3:0]          m_axi_awqos,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arlock,
  output logic [3:0]          m_axi_arcache,
  output logic [3:0]          m_axi_arqos,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  localparam int CNT_W = $clog2(POLL_MAX + 1);
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [CNT_W-1:0] POLL_MAX_C = CNT_W'(POLL_MAX);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [31:0]      result_q, result_d;
  logic             error_q, error_d, timeout_q, timeout_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic             accept_s, ar_load_s, aw_hs_s, w_hs_s, ar_hs_s;
  logic             aw_fin_s, w_fin_s, fin_s, fin_err_s, fin_to_s;
  logic             b_err_s, r_err_s;
  logic [31:0]      w_payload_s;
  logic             unused_s;

  axi_single_beat_chan #(.W(ADDR_W)) u_aw (
    .clk_i(clk), .rst_ni(reset), .load_i(accept_s), .payload_i(INSTR_ADDR),
    .ready_i(m_axi_awready), .valid_o(m_axi_awvalid), .payload_o(m_axi_awaddr)
  );

  axi_single_beat_chan #(.W(32)) u_w (
    .clk_i(clk), .rst_ni(reset), .load_i(accept_s), .payload_i(instr),
    .ready_i(m_axi_wready), .valid_o(m_axi_wvalid), .payload_o(w_payload_s)
  );

  axi_single_beat_chan #(.W(ADDR_W)) u_ar (
    .clk_i(clk), .rst_ni(reset), .load_i(ar_load_s), .payload_i(PRED_ADDR),
    .ready_i(m_axi_arready), .valid_o(m_axi_arvalid), .payload_o(m_axi_araddr)
  );

  assign aw_hs_s   = m_axi_awvalid & m_axi_awready;
  assign w_hs_s    = m_axi_wvalid & m_axi_wready;
  assign ar_hs_s   = m_axi_arvalid & m_axi_arready;
  assign aw_fin_s  = aw_done_q | aw_hs_s;
  assign w_fin_s   = w_done_q | w_hs_s;
  assign b_err_s   = (m_axi_bresp != AXI_RESP_OKAY) || (m_axi_bid != AXI_ID);
  assign r_err_s   = (m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rid != AXI_ID) || !m_axi_rlast;
  assign cnt_inc_s = (cnt_q == POLL_MAX_C) ? cnt_q : cnt_q + CNT_W'(1);
  assign unused_s  = ^m_axi_rdata[DATA_W-1:32];

  // Next-state logic: one write, then read polls separated by a gap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    result_d  = result_q;
    error_d   = error_q;
    timeout_d = timeout_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    accept_s  = 1'b0;
    ar_load_s = 1'b0;
    fin_s     = 1'b0;
    fin_err_s = 1'b0;
    fin_to_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept_s  = 1'b1;
          busy_d    = 1'b1;
          error_d   = 1'b0;
          timeout_d = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        aw_done_d = aw_fin_s;
        w_done_d  = w_fin_s;
        if (aw_fin_s && w_fin_s) begin
          state_d = ST_WRESP;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRESP: begin
        if (m_axi_bvalid && b_err_s) begin
          fin_s     = 1'b1;
          fin_err_s = 1'b1;
        end else if (m_axi_bvalid) begin
          cnt_d     = {CNT_W{1'b0}};
          ar_load_s = 1'b1;
          state_d   = ST_RADDR;
        end else begin
          state_d = ST_WRESP;
        end
      end
      ST_RADDR: begin
        if (ar_hs_s) begin
          state_d = ST_RDATA;
        end else begin
          state_d = ST_RADDR;
        end
      end
      ST_RDATA: begin
        if (m_axi_rvalid) begin
          cnt_d    = cnt_inc_s;
          result_d = m_axi_rdata[31:0];
          // Valid bit wins over the poll limit on the last allowed read.
          if (r_err_s) begin
            fin_s     = 1'b1;
            fin_err_s = 1'b1;
          end else if (m_axi_rdata[PRED_VALID_BIT]) begin
            fin_s = 1'b1;
          end else if (cnt_inc_s == POLL_MAX_C) begin
            fin_s    = 1'b1;
            fin_to_s = 1'b1;
          end else if (POLL_GAP == 0) begin
            ar_load_s = 1'b1;
            state_d   = ST_RADDR;
          end else begin
            gap_d   = {GAP_W{1'b0}};
            state_d = ST_GAP;
          end
        end else begin
          state_d = ST_RDATA;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          ar_load_s = 1'b1;
          state_d   = ST_RADDR;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (fin_s) begin
      state_d   = ST_FIN;
      done_d    = 1'b1;
      busy_d    = 1'b0;
      error_d   = fin_err_s;
      timeout_d = fin_to_s;
    end else begin
      done_d = 1'b0;
    end
  end

  // State and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      gap_q     <= {GAP_W{1'b0}};
      result_q  <= 32'h0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      result_q  <= result_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign error   = error_q;
  assign timeout = timeout_q;

  assign m_axi_awid    = AXI_ID;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = AXI_SIZE_16B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AXI_CACHE_BM;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wdata   = {{(DATA_W-32){1'b0}}, w_payload_s};
  assign m_axi_wstrb   = {{(DATA_W/8-4){1'b0}}, 4'hF};
  assign m_axi_wlast   = 1'b1;
  assign m_axi_bready  = (state_q == ST_WRESP);
  assign m_axi_arid    = AXI_ID;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = AXI_SIZE_16B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXI_CACHE_BM;
  assign m_axi_arqos   = 4'd0;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = (state_q == ST_RDATA);

endmodule
